// File: rtl/retire_queue.sv
// In-order retirement queue: slots are allocated at dispatch, marked done from the
// completion bus, and retired strictly oldest-first with a registered tag return.
module retire_queue #(
  parameter int DSIZE = 5,
  parameter int ASIZE = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Dispatch_en,
  input  logic [DSIZE-1:0] Dispatch_Tag,
  input  logic             Cdb_Valid,
  input  logic [DSIZE-1:0] Cdb_Tag,
  output logic [DSIZE-1:0] RB_Tag,
  output logic             RB_Tag_Valid,
  output logic             Rq_full,
  output logic             Rq_empty,
  output logic [ASIZE:0]   Rq_count
);

  localparam int DEPTH = 1 << ASIZE;

  logic [ASIZE:0]   head_q, head_d;
  logic [ASIZE:0]   tail_q, tail_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DSIZE-1:0] tag_q [DEPTH];
  logic [DSIZE-1:0] rb_tag_q, rb_tag_d;
  logic             rb_valid_q, rb_valid_d;

  logic             dispatch_s;
  logic             retire_s;
  logic [ASIZE-1:0] head_idx_s;
  logic [ASIZE-1:0] tail_idx_s;

  assign head_idx_s   = head_q[ASIZE-1:0];
  assign tail_idx_s   = tail_q[ASIZE-1:0];
  assign Rq_empty     = (head_q == tail_q);
  assign Rq_full      = (head_q[ASIZE] != tail_q[ASIZE]) && (head_idx_s == tail_idx_s);
  assign Rq_count     = tail_q - head_q;
  assign RB_Tag       = rb_tag_q;
  assign RB_Tag_Valid = rb_valid_q;

  // Next-state: completion marking, then retirement at head, then allocation at tail.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rb_tag_d   = rb_tag_q;
    rb_valid_d = 1'b0;

    dispatch_s = Dispatch_en && !Rq_full;
    retire_s   = !Rq_empty && done_q[head_idx_s];

    // Only slots already busy before this edge can match, so a same-cycle dispatch never does.
    for (int i = 0; i < DEPTH; i++) begin
      if (Cdb_Valid && busy_q[i] && (tag_q[i] == Cdb_Tag)) begin
        done_d[i] = 1'b1;
      end else begin
        done_d[i] = done_q[i];
      end
    end

    if (retire_s) begin
      rb_tag_d           = tag_q[head_idx_s];
      rb_valid_d         = 1'b1;
      busy_d[head_idx_s] = 1'b0;
      done_d[head_idx_s] = 1'b0;
      head_d             = head_q + {{ASIZE{1'b0}}, 1'b1};
    end else begin
      rb_valid_d = 1'b0;
    end

    if (dispatch_s) begin
      busy_d[tail_idx_s] = 1'b1;
      done_d[tail_idx_s] = 1'b0;
      tail_d             = tail_q + {{ASIZE{1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end
  end

  // Control state: pointers, slot status bits and the registered retire outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= {(ASIZE+1){1'b0}};
      tail_q     <= {(ASIZE+1){1'b0}};
      busy_q     <= {DEPTH{1'b0}};
      done_q     <= {DEPTH{1'b0}};
      rb_tag_q   <= {DSIZE{1'b0}};
      rb_valid_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rb_tag_q   <= rb_tag_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // Tag storage carries no reset; busy gates every use of it.
  always_ff @(posedge clock) begin
    if (dispatch_s) begin
      tag_q[tail_idx_s] <= Dispatch_Tag;
    end
  end

endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue: linear steps with hand-computed expectations.
module tb_retire_queue;

  logic       clock;
  logic       reset;
  logic       Dispatch_en;
  logic [4:0] Dispatch_Tag;
  logic       Cdb_Valid;
  logic [4:0] Cdb_Tag;
  logic [4:0] RB_Tag;
  logic       RB_Tag_Valid;
  logic       Rq_full;
  logic       Rq_empty;
  logic [5:0] Rq_count;

  int passed = 0;
  int total  = 0;

  retire_queue #(.DSIZE(5), .ASIZE(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .Dispatch_en  (Dispatch_en),
    .Dispatch_Tag (Dispatch_Tag),
    .Cdb_Valid    (Cdb_Valid),
    .Cdb_Tag      (Cdb_Tag),
    .RB_Tag       (RB_Tag),
    .RB_Tag_Valid (RB_Tag_Valid),
    .Rq_full      (Rq_full),
    .Rq_empty     (Rq_empty),
    .Rq_count     (Rq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic den, input logic [4:0] dtag, input logic cv, input logic [4:0] ctag);
    Dispatch_en  = den;
    Dispatch_Tag = dtag;
    Cdb_Valid    = cv;
    Cdb_Tag      = ctag;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    #2;
    check("rst_empty", Rq_empty, 1);
    check("rst_full", Rq_full, 0);
    check("rst_count", Rq_count, 0);
    check("rst_valid", RB_Tag_Valid, 0);
    check("rst_tag", RB_Tag, 0);
    step();
    reset = 1'b1;

    // Dispatch 3, 7, 9
    drive(1'b1, 5'd3, 1'b0, 5'd0); step();
    drive(1'b1, 5'd7, 1'b0, 5'd0); step();
    drive(1'b1, 5'd9, 1'b0, 5'd0); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("disp3_count", Rq_count, 3);
    check("disp3_empty", Rq_empty, 0);
    check("disp3_valid", RB_Tag_Valid, 0);

    // Complete out of order: 9, 7, then 3
    drive(1'b0, 5'd0, 1'b1, 5'd9); step();
    check("cdb9_noret", RB_Tag_Valid, 0);
    drive(1'b0, 5'd0, 1'b1, 5'd7); step();
    check("cdb7_noret", RB_Tag_Valid, 0);
    drive(1'b0, 5'd0, 1'b1, 5'd3); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("cdb3_lat", RB_Tag_Valid, 0);
    step();
    check("ret0_valid", RB_Tag_Valid, 1);
    check("ret0_tag", RB_Tag, 3);
    step();
    check("ret1_valid", RB_Tag_Valid, 1);
    check("ret1_tag", RB_Tag, 7);
    step();
    check("ret2_valid", RB_Tag_Valid, 1);
    check("ret2_tag", RB_Tag, 9);
    check("ret2_empty", Rq_empty, 1);
    step();
    check("post_valid", RB_Tag_Valid, 0);
    check("post_hold", RB_Tag, 9);

    // Completion of a tag in its own dispatch cycle is ignored
    drive(1'b1, 5'd12, 1'b1, 5'd12); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    step(); step();
    check("same_cyc_valid", RB_Tag_Valid, 0);
    check("same_cyc_count", Rq_count, 1);
    drive(1'b0, 5'd0, 1'b1, 5'd12); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0); step();
    check("late12_valid", RB_Tag_Valid, 1);
    check("late12_tag", RB_Tag, 12);
    check("late12_empty", Rq_empty, 1);

    // Fill from a clean reset so the tail wraps to index 0 later
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 1'b0, 5'd0);
      step();
    end
    check("fill_full", Rq_full, 1);
    check("fill_count", Rq_count, 32);
    drive(1'b1, 5'd5, 1'b0, 5'd0); step();
    check("over_count", Rq_count, 32);
    check("over_full", Rq_full, 1);
    drive(1'b0, 5'd0, 1'b1, 5'd0); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("full_lat", RB_Tag_Valid, 0);
    step();
    check("full_ret_valid", RB_Tag_Valid, 1);
    check("full_ret_tag", RB_Tag, 0);
    check("full_ret_count", Rq_count, 31);
    drive(1'b1, 5'd20, 1'b0, 5'd0); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("wrap_count", Rq_count, 32);
    check("wrap_full", Rq_full, 1);

    // Younger entry done first must not retire ahead of the head
    drive(1'b0, 5'd0, 1'b1, 5'd3); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0); step();
    check("order_hold", RB_Tag_Valid, 0);

    // Full queue, head done, dispatch on the retiring edge is rejected
    drive(1'b0, 5'd0, 1'b1, 5'd1); step();
    drive(1'b1, 5'd25, 1'b0, 5'd0); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    check("fr_valid", RB_Tag_Valid, 1);
    check("fr_tag", RB_Tag, 1);
    check("fr_count", Rq_count, 31);
    check("fr_full", Rq_full, 0);

    // Mid-operation reset with entries in flight and a retirement pulse live
    reset = 1'b0; step(); reset = 1'b1;
    for (int i = 10; i < 15; i++) begin
      drive(1'b1, 5'(i), 1'b0, 5'd0);
      step();
    end
    drive(1'b0, 5'd0, 1'b1, 5'd13); step();
    drive(1'b0, 5'd0, 1'b1, 5'd10); step();
    drive(1'b0, 5'd0, 1'b0, 5'd0); step();
    check("pre_rst_valid", RB_Tag_Valid, 1);
    check("pre_rst_tag", RB_Tag, 10);
    check("pre_rst_count", Rq_count, 4);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", RB_Tag_Valid, 0);
    check("mid_rst_tag", RB_Tag, 0);
    check("mid_rst_count", Rq_count, 0);
    check("mid_rst_empty", Rq_empty, 1);
    step();
    reset = 1'b1;
    step(); step(); step();
    check("after_rst_valid", RB_Tag_Valid, 0);
    check("after_rst_empty", Rq_empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
